// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths and bus-source encoding for the datapath
package datapath_pkg;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RAM_DEPTH = 16;
    typedef enum logic [2:0] {
        SRC_NONE, SRC_PC, SRC_A, SRC_B, SRC_IR, SRC_RAM, SRC_ALU, SRC_CONFLICT
    } bus_src_t;
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational 9-bit add/subtract with carry and zero flags
// Ports: i_a, i_b operands; i_sub selects A + ~B + 1; o_sum 9-bit result; o_carry = o_sum[8]; o_zero = (o_sum[7:0] == 0)
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W:0]   o_sum,
    output logic              o_carry,
    output logic              o_zero
);
    always_comb begin
        o_sum   = {1'b0, i_a} + {1'b0, i_sub ? ~i_b : i_b} + (DATA_W+1)'(i_sub);
        o_carry = o_sum[DATA_W];
        o_zero  = o_sum[DATA_W-1:0] == '0;
    end
endmodule

// File: rtl/datapath.sv
// datapath: SAP-style 8-bit datapath with shared bus, PC, A/B, IR, MAR, 16x8 RAM and output register
// Ports: clk, rst (sync, active-high), clk_halt freeze; bus driver/reader controls; load_* RAM program port (rst only);
//        instruction = IR[7:4]; alu_carry/alu_zero latched flags; bus_value/bus_conflict live bus; out_value/out_valid display
module datapath
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_halt,
    input  logic              pc_inc,
    input  logic              pc_jump,
    input  logic              pc_out,
    input  logic              a_reg_read_from_bus,
    input  logic              a_reg_write_to_bus,
    input  logic              b_reg_read_from_bus,
    input  logic              b_reg_write_to_bus,
    input  logic              i_reg_read_from_bus,
    input  logic              i_reg_write_to_bus,
    input  logic              mar_read_from_bus,
    input  logic              ram_read_from_bus,
    input  logic              ram_write_to_bus,
    input  logic              alu_out,
    input  logic              alu_subtract,
    input  logic              alu_flags_in,
    input  logic              out_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_we,
    output logic [3:0]        instruction,
    output logic              alu_carry,
    output logic              alu_zero,
    output logic [DATA_W-1:0] bus_value,
    output logic              bus_conflict,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid
);
    logic [ADDR_W-1:0] r_pc, r_mar;
    logic [DATA_W-1:0] r_a, r_b, r_ir, r_out;
    logic              r_carry, r_zero, r_valid;
    logic [DATA_W-1:0] r_ram [RAM_DEPTH];
    logic [2:0]        w_cnt;
    bus_src_t          w_src;
    logic [DATA_W:0]   w_sum;
    logic              w_c, w_z, w_upd;

    datapath_alu u_alu (.i_a(r_a), .i_b(r_b), .i_sub(alu_subtract), .o_sum(w_sum), .o_carry(w_c), .o_zero(w_z));

    always_comb begin
        w_cnt = 3'(pc_out) + 3'(a_reg_write_to_bus) + 3'(b_reg_write_to_bus)
              + 3'(i_reg_write_to_bus) + 3'(ram_write_to_bus) + 3'(alu_out);
        w_src = w_cnt > 3'd1        ? SRC_CONFLICT :
                pc_out              ? SRC_PC  :
                a_reg_write_to_bus  ? SRC_A   :
                b_reg_write_to_bus  ? SRC_B   :
                i_reg_write_to_bus  ? SRC_IR  :
                ram_write_to_bus    ? SRC_RAM :
                alu_out             ? SRC_ALU : SRC_NONE;
        bus_value = w_src == SRC_PC  ? {4'h0, r_pc} :
                    w_src == SRC_A   ? r_a :
                    w_src == SRC_B   ? r_b :
                    w_src == SRC_IR  ? {4'h0, r_ir[3:0]} :
                    w_src == SRC_RAM ? r_ram[r_mar] :
                    w_src == SRC_ALU ? w_sum[DATA_W-1:0] : '0;
        bus_conflict = w_src == SRC_CONFLICT;
        // any edge that is neither halted nor in bus conflict may commit state
        w_upd = !clk_halt && !bus_conflict;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_mar   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ir    <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_upd && out_en;
            if (w_upd) begin
                r_pc <= pc_jump ? bus_value[ADDR_W-1:0] : pc_inc ? r_pc + 1'b1 : r_pc;
                if (mar_read_from_bus)   r_mar <= bus_value[ADDR_W-1:0];
                if (a_reg_read_from_bus) r_a   <= bus_value;
                if (b_reg_read_from_bus) r_b   <= bus_value;
                if (i_reg_read_from_bus) r_ir  <= bus_value;
                if (out_en)              r_out <= bus_value;
                if (alu_flags_in) begin
                    r_carry <= w_c;
                    r_zero  <= w_z;
                end
            end
        end
    end

    // RAM is never cleared; during rst only the load port may write it
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load_we) r_ram[load_addr] <= load_data;
        end else if (w_upd && ram_read_from_bus) begin
            r_ram[r_mar] <= bus_value;
        end
    end

    assign instruction = r_ir[7:4];
    assign alu_carry   = r_carry;
    assign alu_zero    = r_zero;
    assign out_value   = r_out;
    assign out_valid   = r_valid;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: randomized scoreboard bench for datapath against a behavioural model
module tb_datapath;
    localparam logic [18:0] C_RST = 19'h00001, C_HALT = 19'h00002, C_PCINC = 19'h00004, C_PCJMP = 19'h00008;
    localparam logic [18:0] C_PCOUT = 19'h00010, C_ARD = 19'h00020, C_AWR = 19'h00040, C_BRD = 19'h00080;
    localparam logic [18:0] C_BWR = 19'h00100, C_IRD = 19'h00200, C_IWR = 19'h00400, C_MARRD = 19'h00800;
    localparam logic [18:0] C_RAMRD = 19'h01000, C_RAMWR = 19'h02000, C_ALU = 19'h04000, C_SUB = 19'h08000;
    localparam logic [18:0] C_FLG = 19'h10000, C_OUT = 19'h20000, C_LWE = 19'h40000;
    localparam logic [7:0] INIT [16] = '{8'h1E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                         8'h88, 8'h07, 8'h02, 8'h01, 8'hFF, 8'h03, 8'h05, 8'hA5};

    logic       clk = 0;
    logic [18:0] c = C_RST;
    logic [3:0] la = 0;
    logic [7:0] ld = 0;
    logic [3:0] instruction;
    logic       alu_carry, alu_zero, bus_conflict, out_valid;
    logic [7:0] bus_value, out_value;

    logic [3:0] m_pc, m_mar;
    logic [7:0] m_a, m_b, m_ir, m_out;
    logic       m_c, m_z;
    logic [7:0] m_ram [16];
    logic [7:0] q [$];
    int checks = 0, errors = 0;
    bit mon_en = 0;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .rst(c[0]), .clk_halt(c[1]), .pc_inc(c[2]), .pc_jump(c[3]), .pc_out(c[4]),
        .a_reg_read_from_bus(c[5]), .a_reg_write_to_bus(c[6]), .b_reg_read_from_bus(c[7]),
        .b_reg_write_to_bus(c[8]), .i_reg_read_from_bus(c[9]), .i_reg_write_to_bus(c[10]),
        .mar_read_from_bus(c[11]), .ram_read_from_bus(c[12]), .ram_write_to_bus(c[13]),
        .alu_out(c[14]), .alu_subtract(c[15]), .alu_flags_in(c[16]), .out_en(c[17]),
        .load_addr(la), .load_data(ld), .load_we(c[18]),
        .instruction(instruction), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .bus_value(bus_value), .bus_conflict(bus_conflict), .out_value(out_value), .out_valid(out_valid)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int drivers(input logic [18:0] v);
        return int'(v[4]) + int'(v[6]) + int'(v[8]) + int'(v[10]) + int'(v[13]) + int'(v[14]);
    endfunction

    // full 9-bit ALU result: subtraction is A + (256 - B), so carry means A >= B
    function automatic int alu_full(input logic [7:0] a, input logic [7:0] b, input logic sub);
        return sub ? int'(a) + 256 - int'(b) : int'(a) + int'(b);
    endfunction

    function automatic logic [7:0] exp_bus(input logic [18:0] v);
        if (drivers(v) != 1) return 8'h00;
        if (v[4])  return {4'h0, m_pc};
        if (v[6])  return m_a;
        if (v[8])  return m_b;
        if (v[10]) return {4'h0, m_ir[3:0]};
        if (v[13]) return m_ram[m_mar];
        return 8'((alu_full(m_a, m_b, v[15])) % 256);
    endfunction

    task automatic step(input logic [18:0] v, input logic [3:0] a = 0, input logic [7:0] d = 0);
        logic [7:0] eb;
        int full;
        @(negedge clk);
        c = v; la = a; ld = d;
        #1;
        eb = exp_bus(v);
        chk("bus_value", bus_value, eb);
        chk("bus_conflict", {7'h0, bus_conflict}, {7'h0, drivers(v) > 1});
        @(posedge clk);
        if (v[0]) begin
            m_pc = 0; m_mar = 0; m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_c = 0; m_z = 0;
            if (v[18]) m_ram[a] = d;
        end else if (!v[1] && drivers(v) <= 1) begin
            full = alu_full(m_a, m_b, v[15]);
            if (v[12]) m_ram[m_mar] = eb;
            if (v[11]) m_mar = eb[3:0];
            if (v[3]) m_pc = eb[3:0];
            else if (v[2]) m_pc = m_pc + 4'd1;
            if (v[5]) m_a = eb;
            if (v[7]) m_b = eb;
            if (v[9]) m_ir = eb;
            if (v[16]) begin
                m_c = full >= 256;
                m_z = full % 256 == 0;
            end
            if (v[17]) begin
                m_out = eb;
                q.push_back(eb);
            end
        end
    endtask

    task automatic goto_pc(input logic [3:0] k);
        for (int n = 0; n < 16 && m_pc != k; n++) step(C_PCINC);
    endtask

    task automatic load_reg(input logic [3:0] addr, input logic [18:0] rd);
        goto_pc(addr);
        step(C_PCOUT | C_MARRD);
        step(C_RAMWR | rd);
    endtask

    // monitor: every output pulse must match the oldest expected capture
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (q.size() > 0) begin
                    chk("out_valid", {7'h0, out_valid}, 8'h01);
                    chk("out_capture", out_value, q.pop_front());
                end else begin
                    chk("out_valid_idle", {7'h0, out_valid}, 8'h00);
                end
                chk("out_value", out_value, m_out);
                chk("alu_carry", {7'h0, alu_carry}, {7'h0, m_c});
                chk("alu_zero", {7'h0, alu_zero}, {7'h0, m_z});
                chk("instruction", {4'h0, instruction}, {4'h0, m_ir[7:4]});
            end
        end
    end

    initial begin
        logic [18:0] r;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        for (int i = 0; i < 16; i++) step(C_RST | C_LWE, 4'(i), INIT[i]);
        mon_en = 1;
        step(19'h0);
        step(C_PCOUT | C_MARRD);
        step(C_RAMWR | C_IRD);
        step(C_IWR);
        chk("ir_opcode", {4'h0, instruction}, 8'h01);
        load_reg(14, C_ARD);
        load_reg(13, C_BRD);
        step(C_ALU | C_ARD | C_FLG);
        step(C_AWR | C_OUT);
        load_reg(12, C_ARD);
        load_reg(11, C_BRD);
        step(C_ALU | C_ARD | C_FLG);
        step(C_AWR | C_OUT);
        load_reg(13, C_ARD);
        load_reg(13, C_BRD);
        step(C_ALU | C_SUB | C_FLG | C_OUT);
        load_reg(10, C_ARD);
        step(C_ALU | C_SUB | C_FLG | C_OUT);
        goto_pc(15);
        step(C_PCINC);
        step(C_PCOUT | C_OUT);
        goto_pc(9);
        step(C_PCOUT | C_MARRD);
        step(C_RAMWR | C_PCJMP | C_PCINC);
        step(C_PCOUT | C_OUT);
        step(C_PCOUT | C_AWR | C_BRD);
        step(C_BWR | C_OUT);
        step(C_HALT | C_OUT | C_AWR | C_ARD | C_PCINC);
        step(19'h0);
        step(C_ALU | C_ARD | C_FLG | C_RST);
        step(C_AWR | C_OUT);
        for (int i = 0; i < 16; i++) load_reg(4'(i), C_OUT);
        for (int n = 0; n < 400; n++) begin
            r = '0;
            r[0] = $urandom_range(0, 39) == 0;
            r[1] = $urandom_range(0, 9) == 0;
            for (int b = 2; b < 19; b++) r[b] = $urandom_range(0, 4) == 0;
            step(r, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
        step(19'h0);
        @(negedge clk);
        #1;
        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  input  1  system clock; all datapath state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 clk_halt  input  1  when 1, freezes all state except the RAM load port.
REQ-004 pc_inc, pc_jump, pc_out  input  1 each  program counter controls.
REQ-005 a_reg_read_from_bus, a_reg_write_to_bus, b_reg_read_from_bus, b_reg_write_to_bus  input  1 each  A/B register controls.
REQ-006 i_reg_read_from_bus, i_reg_write_to_bus, mar_read_from_bus, ram_read_from_bus, ram_write_to_bus  input  1 each  IR/MAR/RAM controls.
REQ-007 alu_out, alu_subtract, alu_flags_in, out_en  input  1 each  ALU and output controls.
REQ-008 load_addr  input  4  RAM program-load address.
REQ-009 load_data  input  8  RAM program-load data.
REQ-010 load_we  input  1  RAM program-load write strobe; honoured only while rst=1.
REQ-011 instruction  output  4  opcode, equal to IR[7:4], fed to the control unit.
REQ-012 alu_carry, alu_zero  output  1 each  latched ALU flags.
REQ-013 bus_value  output  8  current resolved bus value (debug).
REQ-014 bus_conflict  output  1  combinational; 1 when more than one bus driver is enabled.
REQ-015 out_value  output  8  output display register.
REQ-016 out_valid  output  1  one-cycle pulse following an out_en capture.

Function
REQ-017 Bus drivers: pc_out -> {4'h0,PC}; a_reg_write_to_bus -> A; b_reg_write_to_bus -> B; i_reg_write_to_bus -> {4'h0,IR[3:0]}; ram_write_to_bus -> RAM[MAR]; alu_out -> SUM[7:0]; no driver -> 8'h00.
REQ-018 Two or more drivers enabled: bus_value SHALL be 8'h00, bus_conflict=1, and no register, RAM, PC, flag or out update occurs that cycle.
REQ-019 SUM SHALL be 9 bits: A + B when alu_subtract=0; A + ~B + 1 when alu_subtract=1; SUM is combinational from the current A and B.
REQ-020 alu_flags_in at posedge: alu_carry <= SUM[8]; alu_zero <= (SUM[7:0]==0); otherwise the flags hold.
REQ-021 Each *_read_from_bus at posedge latches bus_value into its target; MAR and PC take bus[3:0]; ram_read_from_bus writes RAM[MAR].
REQ-022 PC: pc_jump has priority over pc_inc; pc_inc wraps 4'hF -> 4'h0.
REQ-023 A register may read the bus while driving it (e.g. alu_out with a_reg_read_from_bus); the new value uses pre-edge A/B.
REQ-024 out_en at posedge: out_value <= bus_value; out_valid=1 for exactly the next cycle; out_value holds otherwise.
REQ-025 clk_halt=1: all updates of REQ-020..REQ-024 are suppressed and out_valid=0; combinational outputs stay live.
REQ-026 RAM: 16x8, asynchronous read, synchronous write, contents not cleared by rst.

Reset
REQ-027 rst=1 at posedge: PC, A, B, IR, MAR, alu_carry, alu_zero and out_value SHALL be 0, and out_valid SHALL be 0.
REQ-028 While rst=1 and load_we=1: RAM[load_addr] <= load_data; all control inputs are ignored.
REQ-029 rst asserted mid-instruction SHALL take priority over every control input in the same cycle.

Structure
REQ-030 The shared package SHALL hold the constants DATA_W=8, ADDR_W=4 and RAM_DEPTH=16, plus a bus-source enum (SRC_NONE, SRC_PC, SRC_A, SRC_B, SRC_IR, SRC_RAM, SRC_ALU, SRC_CONFLICT).
REQ-031 A single sub-module, datapath_alu (combinational SUM/flag generation), SHALL be used; bus mux and registers stay in datapath.

Verification
REQ-032 Load with rst=1: RAM[0]=8'h1E, RAM[14]=8'h05; release rst; pc_out+mar_read, then ram_write_to_bus+i_reg_read -> instruction=4'h1, i_reg_write_to_bus gives bus=8'h0E.
REQ-033 A=8'h05, B=8'h03, alu_out+a_reg_read+alu_flags_in -> A=8'h08, carry=0, zero=0; same with A=8'hFF, B=8'h01 -> A=8'h00, carry=1, zero=1.
REQ-034 Subtract with A=8'h03, B=8'h03 -> SUM=8'h00, carry=1, zero=1; with A=8'h02, B=8'h03 -> 8'hFF, carry=0, zero=0.
REQ-035 PC=4'hF with pc_inc -> PC=4'h0; pc_inc+pc_jump with bus=8'h07 -> PC=4'h7.
REQ-036 pc_out+a_reg_write_to_bus+b_reg_read -> bus_conflict=1, bus=8'h00, B unchanged; clk_halt=1 with out_en -> out_value unchanged, out_valid=0.
REQ-037 rst pulse mid-sequence with a_reg_read active -> all registers and flags 0 on the next cycle; RAM contents preserved.
